sram_array_ctrl: RTL and testbench

//   Parametrised synchronous single-port SRAM array, DEPTH words x WIDTH bits.

---
 rtl/sram_array_ctrl.sv | 120 ++++++++++++
 tb/tb_sram_array_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl -- synchronous single-port SRAM array, DEPTH x WIDTH.
//
// Registered reads with a one-cycle valid strobe. After reset, an INIT sweep
// writes zero to every word, one word per cycle, before requests are accepted.
//
// Ports:
//   clk        in   1       clock, rising-edge
//   rst        in   1       synchronous active-high reset
//   Write      in   1       write request (sampled only while Ready=1)
//   Read       in   1       read request (sampled only while Ready=1)
//   Addr       in   ADDR_W  word address
//   Data       in   WIDTH   write data
//   Q          out  WIDTH   read data register, holds between reads
//   ReadValid  out  1       pulse: Q was loaded by the previous-cycle read
//   Ready      out  1       array is in IDLE and accepts requests
//   Collision  out  1       pulse: Write and Read both high in an accepted cycle
module sram_array_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Write,
  input  logic              Read,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [WIDTH-1:0]  Data,
  output logic [WIDTH-1:0]  Q,
  output logic              ReadValid,
  output logic              Ready,
  output logic              Collision
);

  if (ADDR_W != $clog2(DEPTH) || DEPTH < 2 || WIDTH < 1) begin : g_bad_params
    $error("sram_array_ctrl: need WIDTH>=1, DEPTH>=2, ADDR_W == $clog2(DEPTH)");
  end

  typedef enum logic {INIT, IDLE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                rv_q, rv_d;
  logic                coll_q, coll_d;
  logic                wr_en, rd_en;
  logic [WIDTH-1:0]    mem [DEPTH];

  // Addresses at or above DEPTH exist only when DEPTH is not a power of two.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the sweep counter stops at DEPTH-1 rather than wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST) state_d = IDLE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    Ready = (state_q == IDLE);
  end

  // Request decode: the write wins a Write/Read collision and the read is dropped.
  always_comb begin
    wr_en  = Ready & Write;
    rd_en  = Ready & Read & ~Write;
    coll_d = Ready & Write & Read;
    rv_d   = rd_en;
    q_d    = q_q;
    if (rd_en) q_d = addr_ok(Addr) ? mem[Addr] : '0;
  end

  // Read-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      rv_q   <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rv_q   <= rv_d;
      coll_q <= coll_d;
    end
  end

  // Storage: rst itself leaves contents alone; the INIT sweep clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT)             mem[cnt_q] <= '0;
      else if (wr_en && addr_ok(Addr)) mem[Addr]  <= Data;
    end
  end

  assign Q         = q_q;
  assign ReadValid = rv_q;
  assign Collision = coll_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl: a DEPTH=16 instance for the main
// behaviour and a DEPTH=10 instance for out-of-range addressing.
module tb_sram_array_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, rd;
  logic [3:0] addr;
  logic [7:0] din, q;
  logic       rv, rdy, col;
  logic       wr10, rd10;
  logic [3:0] addr10;
  logic [7:0] din10, q10;
  logic       rv10, rdy10, col10;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_array_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .Write(wr), .Read(rd), .Addr(addr), .Data(din),
    .Q(q), .ReadValid(rv), .Ready(rdy), .Collision(col)
  );

  sram_array_ctrl #(.WIDTH(8), .DEPTH(10), .ADDR_W(4)) u_dut10 (
    .clk(clk), .rst(rst), .Write(wr10), .Read(rd10), .Addr(addr10), .Data(din10),
    .Q(q10), .ReadValid(rv10), .Ready(rdy10), .Collision(col10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    step();
    wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd = 1'b1; addr = a;
    step();
    rd = 1'b0;
    chk({tag, "_q"}, 32'(q), 32'(exp));
    chk({tag, "_rv"}, 32'(rv), 32'd1);
    step();
    chk({tag, "_rv_drop"}, 32'(rv), 32'd0);
  endtask

  task automatic w10(input logic [3:0] a, input logic [7:0] d);
    wr10 = 1'b1; addr10 = a; din10 = d;
    step();
    wr10 = 1'b0;
  endtask

  task automatic r10(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd10 = 1'b1; addr10 = a;
    step();
    rd10 = 1'b0;
    chk({tag, "_q"}, 32'(q10), 32'(exp));
    chk({tag, "_rv"}, 32'(rv10), 32'd1);
    step();
    chk({tag, "_rv_drop"}, 32'(rv10), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
    wr10 = 1'b0; rd10 = 1'b0; addr10 = '0; din10 = '0;

    // Reset state
    step(); step();
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_ready10", 32'(rdy10), 32'd0);

    // Sweep length; requests issued during INIT must be dropped
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i >= 3 && i <= 5) begin
        wr = 1'b1; rd = 1'b1; addr = 4'd2; din = 8'hFF;
      end else begin
        wr = 1'b0; rd = 1'b0;
      end
      step();
      chk("init_ready", 32'(rdy), 32'(i == 15));
      chk("init_ready10", 32'(rdy10), 32'(i >= 9));
      if (i >= 3 && i <= 5) begin
        chk("init_col", 32'(col), 32'd0);
        chk("init_rv", 32'(rv), 32'd0);
      end
    end
    wr = 1'b0; rd = 1'b0;

    // All words cleared; addr 2 untouched by the INIT-time write
    for (int a = 0; a < 16; a++) do_read("clear", 4'(a), 8'h00);
    do_read("init_ignored_a2", 4'd2, 8'h00);

    // Write then immediate read, Q holds afterwards
    do_write(4'd3, 8'hA5);
    do_read("wr_rd_a3", 4'd3, 8'hA5);
    step(); step(); step();
    chk("hold_q", 32'(q), 32'hA5);

    // Collision: write wins, read dropped, Q unchanged
    wr = 1'b1; rd = 1'b1; addr = 4'd5; din = 8'h3C;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("coll_pulse", 32'(col), 32'd1);
    chk("coll_rv", 32'(rv), 32'd0);
    chk("coll_q", 32'(q), 32'hA5);
    step();
    chk("coll_drop", 32'(col), 32'd0);
    do_read("coll_wr_a5", 4'd5, 8'h3C);

    // Fill with Addr^0x5A
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a) ^ 8'h5A);
    do_read("fill_a0", 4'd0, 8'h5A);
    do_read("fill_a15", 4'd15, 8'h55);

    // Reset kills an in-flight read, then reset again mid-sweep
    rd = 1'b1; addr = 4'd1; rst = 1'b1;
    step();
    rd = 1'b0;
    chk("rst_rv_kill", 32'(rv), 32'd0);
    chk("rst_q_clear", 32'(q), 32'd0);
    chk("rst_ready_low", 32'(rdy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sweep1_ready", 32'(rdy), 32'd0);
    end
    rst = 1'b1;
    step();
    chk("midsweep_rst_ready", 32'(rdy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("sweep2_ready", 32'(rdy), 32'(i == 15));
    end
    for (int a = 0; a < 16; a++) do_read("reclear", 4'(a), 8'h00);

    // DEPTH=10: out-of-range write dropped, read returns 0 with valid
    for (int a = 0; a < 10; a++) w10(4'(a), 8'h10 + 8'(a));
    w10(4'd12, 8'hEE);
    r10("d10_a9", 4'd9, 8'h19);
    r10("d10_oor", 4'd12, 8'h00);
    for (int a = 0; a < 10; a++) r10("d10_keep", 4'(a), 8'h10 + 8'(a));
    chk("d10_col", 32'(col10), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
